// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Front-end sequencer for the 8-bit pipeline. It decodes the opcode leaving
// program memory together with the execute-stage branch outcome, and produces
// the freeze (stall), fetch-gate (stall_pm), squash (flush) and halted
// controls for the PC logic and the IF/ID register.
//
// All four outputs are registered Moore outputs decoded from the next state,
// so they change exactly on the edge that enters a state and carry no
// combinational path from ins_pm, branch_taken or resume.

module pipeline_sequencer #(
  parameter int             OPW          = 5,
  parameter logic [OPW-1:0] LOAD_OP      = 5'b10100,
  parameter logic [OPW-1:0] JUMP_OP      = 5'b10001,
  parameter logic [OPW-1:0] HALT_OP      = 5'b11110,
  parameter int             LOAD_STALL   = 1,  // load bubble cycles, 1..3
  parameter int             JUMP_BUBBLES = 2   // flush cycles, 1..3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins_pm,
  input  logic        branch_taken,
  input  logic        resume,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_STALL  = 2'd1,
    JMP_FLUSH = 2'd2,
    HALT      = 2'd3
  } state_t;

  // Counter reload values: the counter runs down to zero, so an N-cycle
  // window is loaded with N-1.
  localparam logic [1:0] LOAD_RELOAD = 2'(LOAD_STALL - 1);
  localparam logic [1:0] JMP_RELOAD  = 2'(JUMP_BUBBLES - 1);

  state_t         state, state_nxt;
  logic [1:0]     cnt, cnt_nxt;
  logic           skip, skip_nxt;
  logic [OPW-1:0] opcode;

  assign opcode = ins_pm[19:20-OPW];

  // The operand field never influences sequencing.
  logic unused_operand;
  assign unused_operand = ^ins_pm[19-OPW:0];

  // Next-state, counter and skip-flag decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    skip_nxt  = skip;

    case (state)
      RUN: begin
        // skip only guards the single decode right after a freeze; it is
        // consumed on every RUN edge whatever is decoded.
        skip_nxt = 1'b0;
        if (branch_taken) begin
          state_nxt = JMP_FLUSH;
          cnt_nxt   = JMP_RELOAD;
        end else if (opcode == HALT_OP && !skip) begin
          state_nxt = HALT;
        end else if (opcode == JUMP_OP) begin
          state_nxt = JMP_FLUSH;
          cnt_nxt   = JMP_RELOAD;
        end else if (opcode == LOAD_OP && !skip) begin
          state_nxt = LD_STALL;
          cnt_nxt   = LOAD_RELOAD;
        end
      end

      LD_STALL: begin
        if (branch_taken) begin
          state_nxt = JMP_FLUSH;
          cnt_nxt   = JMP_RELOAD;
        end else if (cnt == 2'd0) begin
          // The load is still sitting on ins_pm; do not decode it again.
          state_nxt = RUN;
          skip_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end

      JMP_FLUSH: begin
        if (branch_taken) begin
          // A new taken branch restarts the flush window from this pulse.
          cnt_nxt = JMP_RELOAD;
        end else if (cnt == 2'd0) begin
          state_nxt = RUN;
          skip_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end

      HALT: begin
        // branch_taken and ins_pm are ignored; resume wins over a branch.
        if (resume) begin
          state_nxt = RUN;
          skip_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State registers and Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 2'd0;
      skip     <= 1'b0;
      stall    <= 1'b0;
      stall_pm <= 1'b0;
      flush    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values; blocking ones here would create order-dependent
      // simulation and mismatch the synthesized flops.
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      skip     <= skip_nxt;
      stall    <= (state_nxt == LD_STALL) || (state_nxt == HALT);
      stall_pm <= (state_nxt != RUN);
      flush    <= (state_nxt == JMP_FLUSH);
      halted   <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Directed bench for pipeline_sequencer. Two instances share clock and reset:
// dut uses the default parameters, dut3 uses LOAD_STALL=3 for the
// branch-override scenario. Each step drives inputs, pushes the output
// vector expected after the next rising edge onto a scoreboard queue, then
// pops and compares it 1 ns after that edge.
// Output vectors are packed {stall, stall_pm, flush, halted}.

module tb_pipeline_sequencer;

  localparam logic [3:0] O_RUN  = 4'b0000;
  localparam logic [3:0] O_LD   = 4'b1100;
  localparam logic [3:0] O_JF   = 4'b0110;
  localparam logic [3:0] O_HALT = 4'b1101;

  localparam logic [19:0] I_NOP  = 20'h00000;
  localparam logic [19:0] I_LOAD = 20'hA0000;
  localparam logic [19:0] I_JUMP = 20'h88000;
  localparam logic [19:0] I_HALT = 20'hF0000;
  localparam logic [19:0] I_UNK  = 20'h12345;

  logic        clk = 1'b0;
  logic        reset;

  logic [19:0] ins_a, ins_b;
  logic        bt_a, bt_b, rs_a, rs_b;
  logic        stall_a, stall_pm_a, flush_a, halted_a;
  logic        stall_b, stall_pm_b, flush_b, halted_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ins_pm       (ins_a),
    .branch_taken (bt_a),
    .resume       (rs_a),
    .stall        (stall_a),
    .stall_pm     (stall_pm_a),
    .flush        (flush_a),
    .halted       (halted_a)
  );

  pipeline_sequencer #(.LOAD_STALL(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .ins_pm       (ins_b),
    .branch_taken (bt_b),
    .resume       (rs_b),
    .stall        (stall_b),
    .stall_pm     (stall_pm_b),
    .flush        (flush_b),
    .halted       (halted_b)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock step: drive the selected instance, queue its expectation,
  // clock it, then compare just after the edge.
  task automatic cyc(input string tag, input bit sel, input logic [19:0] ins,
                     input logic bt, input logic rs, input logic [3:0] exp);
    logic [3:0] got;
    logic [3:0] e;
    ins_a = sel ? I_NOP : ins;
    bt_a  = sel ? 1'b0  : bt;
    rs_a  = sel ? 1'b0  : rs;
    ins_b = sel ? ins   : I_NOP;
    bt_b  = sel ? bt    : 1'b0;
    rs_b  = sel ? rs    : 1'b0;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = sel ? {stall_b, stall_pm_b, flush_b, halted_b}
              : {stall_a, stall_pm_a, flush_a, halted_a};
    e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  initial begin
    reset = 1'b1;
    ins_a = I_HALT; bt_a = 1'b0; rs_a = 1'b0;
    ins_b = I_NOP;  bt_b = 1'b0; rs_b = 1'b0;

    // Reset: outputs held low while reset is high, even with HALT on ins_pm.
    #1;
    check("rst_async", {stall_a, stall_pm_a, flush_a, halted_a}, O_RUN);
    @(posedge clk); #1;
    check("rst_edge1", {stall_a, stall_pm_a, flush_a, halted_a}, O_RUN);
    @(posedge clk); #1;
    check("rst_edge2", {stall_a, stall_pm_a, flush_a, halted_a}, O_RUN);
    @(negedge clk);
    reset = 1'b0;

    // First edge after release decodes HALT with skip clear.
    cyc("rst_to_halt", 0, I_HALT, 0, 0, O_HALT);

    // Halt for 5 cycles total, a branch pulse is ignored, resume on 5th edge.
    cyc("halt_c2",       0, I_HALT, 0, 0, O_HALT);
    cyc("halt_br_ign",   0, I_HALT, 1, 0, O_HALT);
    cyc("halt_c4",       0, I_HALT, 0, 0, O_HALT);
    cyc("halt_c5",       0, I_HALT, 0, 0, O_HALT);
    cyc("halt_resume",   0, I_HALT, 0, 1, O_RUN);
    cyc("halt_no_rehalt",0, I_HALT, 0, 0, O_RUN);
    cyc("halt_after",    0, I_NOP,  0, 0, O_RUN);

    // Load held constant: 1-cycle stall, two clear cycles (exit, masked), stall again.
    cyc("ld_stall",      0, I_LOAD, 0, 0, O_LD);
    cyc("ld_exit",       0, I_LOAD, 0, 0, O_RUN);
    cyc("ld_skip",       0, I_LOAD, 0, 0, O_RUN);
    cyc("ld_again",      0, I_LOAD, 0, 0, O_LD);
    cyc("ld_exit2",      0, I_NOP,  0, 0, O_RUN);
    cyc("ld_idle",       0, I_NOP,  0, 0, O_RUN);

    // skip does not mask a jump decoded right after a load.
    cyc("sk_ld",         0, I_LOAD, 0, 0, O_LD);
    cyc("sk_ld_exit",    0, I_JUMP, 0, 0, O_RUN);
    cyc("sk_jump",       0, I_JUMP, 0, 0, O_JF);
    cyc("sk_jump2",      0, I_NOP,  0, 0, O_JF);
    cyc("sk_done",       0, I_NOP,  0, 0, O_RUN);

    // Jump: flush and stall_pm for exactly 2 cycles, stall low.
    cyc("jmp_c1",        0, I_JUMP, 0, 0, O_JF);
    cyc("jmp_c2",        0, I_NOP,  0, 0, O_JF);
    cyc("jmp_done",      0, I_NOP,  0, 0, O_RUN);
    cyc("jmp_idle",      0, I_NOP,  0, 0, O_RUN);

    // Taken branch from RUN behaves like a jump.
    cyc("br_c1",         0, I_NOP,  1, 0, O_JF);
    cyc("br_c2",         0, I_NOP,  0, 0, O_JF);
    cyc("br_done",       0, I_NOP,  0, 0, O_RUN);

    // Unknown opcode is a plain instruction.
    cyc("unk_op",        0, I_UNK,  0, 0, O_RUN);

    // Resume and branch together in HALT: resume wins.
    cyc("hb_halt",       0, I_HALT, 0, 0, O_HALT);
    cyc("hb_resume",     0, I_NOP,  1, 1, O_RUN);
    cyc("hb_idle",       0, I_NOP,  0, 0, O_RUN);

    // Async reset between edges during a flush window.
    cyc("ar_jump",       0, I_JUMP, 0, 0, O_JF);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_clear", {stall_a, stall_pm_a, flush_a, halted_a}, O_RUN);
    check("ar_cnt_clear", {2'b00, dut.cnt}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    cyc("ar_after",      0, I_NOP,  0, 0, O_RUN);

    // LOAD_STALL=3 instance: stall held exactly 3 cycles.
    cyc("l3_c1",         1, I_LOAD, 0, 0, O_LD);
    cyc("l3_c2",         1, I_LOAD, 0, 0, O_LD);
    cyc("l3_c3",         1, I_LOAD, 0, 0, O_LD);
    cyc("l3_exit",       1, I_LOAD, 0, 0, O_RUN);
    cyc("l3_skip",       1, I_NOP,  0, 0, O_RUN);

    // Branch override in LD_STALL, second pulse restarts: 3 flush cycles total.
    cyc("bo_ld1",        1, I_LOAD, 0, 0, O_LD);
    cyc("bo_ld2",        1, I_NOP,  0, 0, O_LD);
    cyc("bo_br1",        1, I_NOP,  1, 0, O_JF);
    cyc("bo_br2",        1, I_NOP,  1, 0, O_JF);
    cyc("bo_f3",         1, I_NOP,  0, 0, O_JF);
    cyc("bo_done",       1, I_NOP,  0, 0, O_RUN);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
